// File: rtl/bcd_display_driver_pkg.sv
// ============================================================================
//  Module   : bcd_display_driver_pkg
//  Purpose  : Shared constants and helpers for the 8-digit seven-segment driver
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_display_driver_pkg;

    localparam int NUM_DIGITS = 8;

    // Decimal point sits after h1, m1 and s1 (slots 6, 4, 2).
    localparam logic [7:0] DP_MASK = 8'b0101_0100;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [7:0] AN_OFF   = 8'hFF;

    // Slot d displays nibble d+1 of the snapshot; ms1 (nibble 0) is never shown.
    function automatic logic [3:0] slot_nibble(input logic [35:0] snap,
                                               input logic [2:0]  slot);
        return snap[4*int'(slot)+4 +: 4];
    endfunction

    function automatic logic [7:0] slot_anode(input logic [2:0] slot);
        return ~(8'b0000_0001 << slot);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_display_driver_bcd_to_seg.sv
// ============================================================================
//  Module   : bcd_to_seg
//  Purpose  : Combinational BCD nibble to active-low seven-segment glyph
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_seg
    import bcd_display_driver_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/bcd_display_driver.sv
// ============================================================================
//  Module   : bcd_display_driver
//  Purpose  : Multiplexed 8-digit display of HH MM SS ms3 ms2 with edit blink
//             and done flash
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_display_driver
    import bcd_display_driver_pkg::*;
#(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] time_bcd,
    input  logic        edit,
    input  logic [2:0]  curr_digit,
    input  logic        done,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int c_scan_w  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int c_blink_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);
    localparam logic [2:0]           c_last_slot  = 3'(NUM_DIGITS - 1);

    logic [c_scan_w-1:0]  r_scan_cnt;
    logic [2:0]           r_digit_idx;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_on;
    logic [35:0]          r_snap;
    logic                 r_first;
    logic [7:0]           r_an;
    logic [6:0]           r_seg;
    logic                 r_dp;

    logic                 w_scan_wrap;
    logic                 w_frame_wrap;
    logic                 w_blink_run;
    logic                 w_blink_wrap;
    logic [3:0]           w_nibble;
    logic [6:0]           w_glyph;
    logic                 w_blank;

    assign w_scan_wrap  = (r_scan_cnt == c_scan_last);
    assign w_frame_wrap = w_scan_wrap && (r_digit_idx == c_last_slot);
    assign w_blink_run  = edit | done;
    assign w_blink_wrap = (r_blink_cnt == c_blink_last);
    assign w_nibble     = slot_nibble(r_snap, r_digit_idx);

    bcd_to_seg u_bcd_to_seg (
        .i_bcd (w_nibble),
        .o_seg (w_glyph)
    );

    // Edit blinking takes priority; done only flashes when not editing.
    always_comb begin
        w_blank = 1'b0;
        if (edit) begin
            if (!r_blink_on && (curr_digit < 3'd6) &&
                (r_digit_idx == (c_last_slot - curr_digit))) begin
                w_blank = 1'b1;
            end
        end else if (done) begin
            w_blank = !r_blink_on;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= 3'd0;
        end else begin
            if (w_scan_wrap) begin
                r_scan_cnt  <= '0;
                r_digit_idx <= r_digit_idx + 3'd1;
            end else begin
                r_scan_cnt  <= r_scan_cnt + 1'b1;
            end
        end
    end

    // Snapshot only at frame boundaries so a frame never mixes two times.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap  <= '0;
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (r_first || w_frame_wrap) begin
                r_snap <= time_bcd;
            end
        end
    end

    // Idle blink state is "lit" so a freshly edited digit appears at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (w_blink_run) begin
            if (w_blink_wrap) begin
                r_blink_cnt <= '0;
                r_blink_on  <= !r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end else begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else if (w_blank) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= slot_anode(r_digit_idx);
            r_seg <= w_glyph;
            r_dp  <= !DP_MASK[r_digit_idx];
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

`default_nettype wire
